// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory read port, redirect input and decode handshake.
// The master modport is the fetch unit's view; slave is the memory/decode/execute side.
interface fetch_unit_if;
  logic [31:0] mem_addr_out;
  logic        mem_read_out;
  logic        mem_valid_in;
  logic [31:0] mem_data_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic        inst_valid_out;
  logic [31:0] inst_data_out;
  logic [31:0] inst_pc_out;
  logic        inst_ready_in;

  modport master (
    output mem_addr_out, mem_read_out, inst_valid_out, inst_data_out, inst_pc_out,
    input  mem_valid_in, mem_data_in, redirect_valid_in, redirect_pc_in, inst_ready_in
  );

  modport slave (
    input  mem_addr_out, mem_read_out, inst_valid_out, inst_data_out, inst_pc_out,
    output mem_valid_in, mem_data_in, redirect_valid_in, redirect_pc_in, inst_ready_in
  );
endinterface

// File: rtl/fetch_unit.sv
// Core101 instruction fetch: one outstanding memory read, 2-entry {pc, word} queue
// towards decode, and redirect handling that drains any read memory cannot abort.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clock_in,
  input  logic         reset_in,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] req_addr_r, req_addr_s;
  logic [1:0]  count_r, count_s;
  logic [31:0] q_pc_r [0:1];
  logic [31:0] q_data_r [0:1];
  logic [31:0] q_pc_s [0:1];
  logic [31:0] q_data_s [0:1];
  logic        mem_read_r, mem_read_s;
  logic        inst_valid_r, inst_valid_s;

  logic [31:0] redirect_pc_s;
  logic        complete_s;
  logic        pop_s;
  logic        push_s;
  logic [1:0]  count_after_pop_s;

  assign bus.mem_addr_out   = req_addr_r;
  assign bus.mem_read_out   = mem_read_r;
  assign bus.inst_valid_out = inst_valid_r;
  assign bus.inst_data_out  = q_data_r[0];
  assign bus.inst_pc_out    = q_pc_r[0];

  // Next-state, queue and PC update logic
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    req_addr_s = req_addr_r;
    q_pc_s     = q_pc_r;
    q_data_s   = q_data_r;

    redirect_pc_s     = {bus.redirect_pc_in[31:2], 2'b00};
    complete_s        = mem_read_r && bus.mem_valid_in;
    // A redirect flushes the queue, so decode never sees a pop in that cycle.
    pop_s             = (count_r != 2'd0) && bus.inst_ready_in && !bus.redirect_valid_in;
    push_s            = (state_r == ST_REQ) && complete_s && !bus.redirect_valid_in;
    count_after_pop_s = count_r - {1'b0, pop_s};

    if (bus.redirect_valid_in) begin
      count_s = 2'd0;
    end else begin
      count_s = count_after_pop_s + {1'b0, push_s};
    end

    // Head lives in slot 0; an emptied queue leaves slot 0 untouched so the outputs hold.
    if (pop_s && (count_r == 2'd2)) begin
      q_pc_s[0]   = q_pc_r[1];
      q_data_s[0] = q_data_r[1];
    end else begin
      q_pc_s[0]   = q_pc_s[0];
    end
    if (push_s) begin
      if (count_after_pop_s == 2'd0) begin
        q_pc_s[0]   = req_addr_r;
        q_data_s[0] = bus.mem_data_in;
      end else begin
        q_pc_s[1]   = req_addr_r;
        q_data_s[1] = bus.mem_data_in;
      end
    end else begin
      q_pc_s[1] = q_pc_s[1];
    end

    if (bus.redirect_valid_in) begin
      pc_s = redirect_pc_s;
      if ((state_r != ST_IDLE) && !complete_s) begin
        state_s = ST_DRAIN;
      end else begin
        req_addr_s = redirect_pc_s;
        state_s    = ST_REQ;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (count_after_pop_s < 2'd2) begin
            req_addr_s = pc_r;
            state_s    = ST_REQ;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (complete_s) begin
            pc_s = req_addr_r + 32'd4;
            if (count_s < 2'd2) begin
              req_addr_s = req_addr_r + 32'd4;
              state_s    = ST_REQ;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            state_s = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (complete_s) begin
            req_addr_s = pc_r;
            state_s    = ST_REQ;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end

    mem_read_s   = (state_s != ST_IDLE);
    inst_valid_s = (count_s != 2'd0);
  end

  // State, queue and registered-output update
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_r      <= ST_IDLE;
      pc_r         <= RESET_PC;
      req_addr_r   <= RESET_PC;
      count_r      <= 2'd0;
      q_pc_r[0]    <= 32'd0;
      q_pc_r[1]    <= 32'd0;
      q_data_r[0]  <= 32'd0;
      q_data_r[1]  <= 32'd0;
      mem_read_r   <= 1'b0;
      inst_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      req_addr_r   <= req_addr_s;
      count_r      <= count_s;
      q_pc_r[0]    <= q_pc_s[0];
      q_pc_r[1]    <= q_pc_s[1];
      q_data_r[0]  <= q_data_s[0];
      q_data_r[1]  <= q_data_s[1];
      mem_read_r   <= mem_read_s;
      inst_valid_r <= inst_valid_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic compared
// every cycle against a queue-based reference model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk;
  logic rst;
  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clock_in (clk),
    .reset_in (rst),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t      mdl_q[$];
  bit          mdl_init;
  bit          mdl_reading;
  bit          mdl_stale;
  logic [31:0] mdl_addr;
  logic [31:0] mdl_pc;
  logic [31:0] hold_pc;
  logic [31:0] hold_data;

  int checks_cnt;
  int errors_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: advances one clock edge using the inputs presented at that edge.
  task automatic model_step(input bit r, input bit v, input logic [31:0] d,
                            input bit rdy, input bit rv, input logic [31:0] rpc);
    bit complete;
    if (r) begin
      mdl_q.delete();
      mdl_reading = 1'b0;
      mdl_stale   = 1'b0;
      mdl_addr    = RST_PC;
      mdl_pc      = RST_PC;
      hold_pc     = 32'd0;
      hold_data   = 32'd0;
      mdl_init    = 1'b1;
    end else begin
      complete = mdl_reading && v;
      if (rv) begin
        mdl_q.delete();
        mdl_pc = rpc & 32'hFFFF_FFFC;
        if (mdl_reading && !complete) begin
          mdl_stale = 1'b1;
        end else begin
          mdl_addr    = mdl_pc;
          mdl_reading = 1'b1;
          mdl_stale   = 1'b0;
        end
      end else begin
        if (mdl_q.size() > 0 && rdy) void'(mdl_q.pop_front());
        if (!mdl_reading) begin
          if (mdl_q.size() < 2) begin
            mdl_addr    = mdl_pc;
            mdl_reading = 1'b1;
          end
        end else if (mdl_stale) begin
          if (complete) begin
            mdl_addr  = mdl_pc;
            mdl_stale = 1'b0;
          end
        end else if (complete) begin
          mdl_q.push_back('{pc: mdl_addr, data: d});
          mdl_pc = mdl_addr + 32'd4;
          if (mdl_q.size() < 2) mdl_addr = mdl_addr + 32'd4;
          else mdl_reading = 1'b0;
        end
      end
      if (mdl_q.size() > 0) begin
        hold_pc   = mdl_q[0].pc;
        hold_data = mdl_q[0].data;
      end
    end
  endtask

  // One cycle: drive inputs, compare outputs mid-cycle, then advance the model at the edge.
  task automatic step(input bit r, input bit v, input logic [31:0] d,
                      input bit rdy, input bit rv, input logic [31:0] rpc);
    rst                   = r;
    bus.mem_valid_in      = v;
    bus.mem_data_in       = d;
    bus.inst_ready_in     = rdy;
    bus.redirect_valid_in = rv;
    bus.redirect_pc_in    = rpc;
    @(negedge clk);
    if (mdl_init) begin
      check_eq("mem_read",   {31'd0, bus.mem_read_out},   {31'd0, mdl_reading});
      check_eq("mem_addr",   bus.mem_addr_out,            mdl_addr);
      check_eq("inst_valid", {31'd0, bus.inst_valid_out}, {31'd0, (mdl_q.size() > 0)});
      check_eq("inst_data",  bus.inst_data_out,  (mdl_q.size() > 0) ? mdl_q[0].data : hold_data);
      check_eq("inst_pc",    bus.inst_pc_out,    (mdl_q.size() > 0) ? mdl_q[0].pc   : hold_pc);
    end
    @(posedge clk);
    model_step(r, v, d, rdy, rv, rpc);
    #1;
  endtask

  initial begin
    clk        = 1'b0;
    checks_cnt = 0;
    errors_cnt = 0;
    mdl_init   = 1'b0;

    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

    // Reset, first fetch and zero-wait streaming of 32'h13
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'h13, 1'b1, 1'b0, 32'd0);

    // Stalled decode, then release
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 32'd0);

    // Wait states: valid after three idle cycles
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, $urandom, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 32'd0);

    // Redirect two cycles into a four-cycle read
    step(1'b0, 1'b0, $urandom, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, $urandom, 1'b1, 1'b1, 32'h0000_0200);
    step(1'b0, 1'b0, $urandom, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 32'd0);

    // Redirect coinciding with completion and pop while one entry is queued
    step(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, $urandom, 1'b1, 1'b1, 32'h0000_0303);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 32'd0);

    // Address wrap, then reset while a read is outstanding
    step(1'b0, 1'b0, $urandom, 1'b1, 1'b1, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, $urandom, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, $urandom, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, $urandom, 1'b1, 1'b0, 32'd0);

    // Random traffic with occasional redirects and resets
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'h0000_000F);
      step($urandom_range(99) < 1, $urandom_range(99) < 55, $urandom,
           $urandom_range(99) < 60, $urandom_range(99) < 6, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for Core101. It sits directly upstream of decode and drives the core's memory read port. It keeps the fetch PC and issues one read at a time using a request/valid handshake. Fetched words are buffered with their PCs in a 2-entry queue that feeds decode through a valid/ready handshake, and a redirect from execute flushes the queue and restarts fetch at a new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset; bits [1:0] must be zero.
- `clock_in` in 1: single clock, all state updates on its rising edge.
- `reset_in` in 1: reset, synchronous and active-high.
- `mem_addr_out` out 32: read address, equal to the registered request address.
- `mem_read_out` out 1: read request, high in states REQ and DRAIN.
- `mem_valid_in` in 1: memory has `mem_data_in` valid for the current request.
- `mem_data_in` in 32: instruction word returned by memory.
- `redirect_valid_in` in 1: redirect fetch; takes priority over all other events.
- `redirect_pc_in` in 32: new fetch PC; bits [1:0] are ignored and treated as 0.
- `inst_valid_out` out 1: queue head holds a valid instruction.
- `inst_data_out` out 32: instruction word at the queue head.
- `inst_pc_out` out 32: PC of the queue-head instruction.
- `inst_ready_in` in 1: decode accepts the head this cycle.

## Operation
- **State registers:** `pc` (next address to fetch), `req_addr` (address of the in-flight read), FSM state, 2-entry queue of {pc, word}, and a 2-bit count (0..2).
- **Handshakes:**
  - Memory transfer completes on any rising edge where `mem_read_out && mem_valid_in`.
  - Pop occurs on any rising edge where `inst_valid_out && inst_ready_in`.
- **Reset:** state=IDLE, `pc`=`RESET_PC`, `req_addr`=`RESET_PC`, count=0, queue storage=0. Resulting outputs: `mem_read_out`=0, `mem_addr_out`=`RESET_PC`, `inst_valid_out`=0, `inst_data_out`=0, `inst_pc_out`=0.
- **IDLE:** `mem_read_out`=0.
  - If the next count (after any pop) is below 2: `req_addr`<=`pc`, go to REQ.
  - Otherwise stay in IDLE.
- **REQ:** `mem_read_out`=1; `mem_addr_out` stays stable until completion.
  - On completion: push {`req_addr`, `mem_data_in`} and set `pc`<=`req_addr`+4.
  - If the count after the push and any pop is below 2: `req_addr`<=`req_addr`+4 and stay in REQ (back-to-back).
  - Otherwise go to IDLE.
- **DRAIN:** `mem_read_out`=1 with the old `req_addr`, because memory cannot abort a read.
  - On completion: discard the data, set `req_addr`<=`pc`, go to REQ.
- **Redirect (any state):**
  - Count<=0, so the queue is flushed and no pop is reported that cycle.
  - `pc`<=`{redirect_pc_in[31:2],2'b00}`.
  - If in REQ or DRAIN and the read does not complete this edge: go to DRAIN.
  - If a completion coincides with the redirect: drop the data, `req_addr`<=redirect PC, go to REQ.
  - If in IDLE: `req_addr`<=redirect PC, go to REQ.
- **Queue:**
  - Simultaneous push and pop keeps the count unchanged; entry order is preserved.
  - The queue never overflows: a read is only issued when a slot is free, and only fetch pushes.
  - When count=0, `inst_data_out` and `inst_pc_out` hold their last values.
- **Width rules:** PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset deasserts at edge 0 → cycle 1: IDLE with `mem_read_out`=0 → cycle 2: `mem_read_out`=1 at `RESET_PC`.
- Memory valid at edge N with an empty queue → `inst_valid_out`=1 in cycle N+1 (1-cycle latency).
- Zero-wait memory with decode always ready sustains one instruction per cycle.
- Decode stalled: at most 2 words are buffered, then `mem_read_out` drops.
- Redirect at edge N from IDLE/REQ with no in-flight read → `mem_read_out` high at the new PC in cycle N+1.
- Redirect with an in-flight read: DRAIN lasts until memory valid, then REQ at the new PC.
- `reset_in` mid-transaction returns every register to its reset value at that edge. Memory must also be reset, since any in-flight read is forgotten.

## Test plan
- **Reset and first fetch:** reset with `RESET_PC`=32'h100, then zero-wait memory returning 32'h13 → `mem_addr_out` sequence 0x100, 0x104, 0x108; `inst_pc_out`=0x100, `inst_data_out`=0x13 in the cycle after the first valid.
- **Stalled decode:** `inst_ready_in`=0, memory always valid → exactly 2 entries (0x100, 0x104) and `mem_read_out`=0. Raising ready pops 0x100 and refetch starts at 0x108.
- **Wait states:** `mem_valid_in` delayed 3 cycles → `mem_read_out` stays high with `mem_addr_out` stable for 4 cycles and exactly one push.
- **Redirect during in-flight read:** redirect to 0x200 two cycles into a 4-cycle read → DRAIN holds the old address, its data is dropped, the next request is at 0x200, and no stale instruction reaches decode.
- **Redirect coincident with completion and pop:** queue holds 1 entry, redirect to 0x303 → count=0, next request at 0x300, data dropped.
- **Wrap and mid-operation reset:** fetch from 0xFFFF_FFFC → next address 0x0. Then `reset_in` during REQ → outputs return to reset values at the next edge.
